// File: rtl/wb_trace_capture.sv
// Writeback trace capture: records retired register writes in a show-ahead FIFO
// and keeps a rotate-XOR signature plus retire/drop counters.
module wb_trace_capture #(
    parameter int unsigned DEPTH     = 16,
    parameter bit          FILTER_X0 = 1'b1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     capture_en,
    input  logic                     clear,
    input  logic                     wb_valid,
    input  logic [4:0]               wb_rd,
    input  logic [31:0]              wb_write_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [36:0]              rd_data,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [31:0]              signature,
    output logic [CNT_W-1:0]         retire_cnt,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic                     overflow
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned LVL_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = 37;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    logic               ev_c;
    logic               full_c;
    logic               pop_c;
    logic               push_c;
    logic               drop_c;
    logic [LVL_W-1:0]   level_nxt_c;

    // Event qualification and FIFO handshake decode
    always_comb begin
        ev_c        = capture_en & wb_valid & ~(FILTER_X0 & (wb_rd == 5'd0));
        full_c      = (fifo_level == LVL_W'(DEPTH));
        pop_c       = rd_valid & rd_ready;
        push_c      = ev_c & (~full_c | pop_c);
        drop_c      = ev_c & full_c & ~pop_c;
        level_nxt_c = fifo_level + LVL_W'(push_c) - LVL_W'(pop_c);
    end

    // Storage needs no reset; only pointer-covered entries are ever read
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= {wb_rd, wb_write_data};
        end
    end

    assign rd_data = mem[rd_ptr];

    // Pointers, level and registered valid
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            rd_valid   <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= PTR_W'(wr_ptr + 1'b1);
            end
            if (pop_c) begin
                rd_ptr <= PTR_W'(rd_ptr + 1'b1);
            end
            fifo_level <= level_nxt_c;
            rd_valid   <= (level_nxt_c != '0);
        end
    end

    // Signature and saturating statistics; drops still sign and count as retired
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            signature  <= '0;
            retire_cnt <= '0;
            drop_cnt   <= '0;
            overflow   <= 1'b0;
        end else begin
            if (ev_c) begin
                signature <= {signature[30:0], signature[31]} ^ wb_write_data;
                if (retire_cnt != '1) begin
                    retire_cnt <= CNT_W'(retire_cnt + 1'b1);
                end
            end
            if (drop_c) begin
                overflow <= 1'b1;
                if (drop_cnt != '1) begin
                    drop_cnt <= CNT_W'(drop_cnt + 1'b1);
                end
            end
        end
    end

endmodule
